// File: rtl/ccc_sup_pkg.sv
// Shared types and sizing helpers for the CCC lock supervisor.
// Latency: n/a (package only).
// Backpressure: n/a.
package ccc_sup_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARST       = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_STABLE_CHK = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAULT      = 3'd5
    } state_e;

    localparam int unsigned LOSS_CNT_W   = 8;
    localparam int unsigned RETRY_CNT_W  = 2;
    localparam int unsigned LOSS_CNT_MAX = 255;

    // Bits needed to hold 0..max_val inclusive, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// N-flop synchronizer for the asynchronous CCC LOCK, cleared to 0 by reset.
// Latency: STAGES clock cycles from d_i to q_o.
// Backpressure: none; free-running shift.
// Ports: clk, rst_n (async active-low), d_i (asynchronous input), q_o (synchronised).
module ccc_lock_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ccc_lock_supervisor.sv
// CCC/PLL bring-up sequencer and lock supervisor on a free-running clock.
// Latency: all outputs registered; decisions use LOCK after LOCK_SYNC_STAGES flops.
// Backpressure: none; level/pulse controls EN, FORCE_REINIT, FAULT_CLR.
// Ports: CLK/RESET_N; EN, FORCE_REINIT, FAULT_CLR, CCC_LOCK in; PLL_POWERDOWN_N,
//        PLL_ARST_N, FABRIC_RESET_N, LOCKED_STABLE, FAULT, STATE, RETRY_CNT, LOSS_CNT out.
// Build option: CCC_SUP_LOSS_CNT_EN keeps the lock-loss counter; otherwise LOSS_CNT is 0.
module ccc_lock_supervisor
    import ccc_sup_pkg::*;
#(
    parameter int unsigned LOCK_SYNC_STAGES     = 2,
    parameter int unsigned ARST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES   = 1024,
    parameter int unsigned UNLOCK_FILTER_CYCLES = 4,
    parameter int unsigned MAX_RETRIES          = 3
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   EN,
    input  logic                   FORCE_REINIT,
    input  logic                   FAULT_CLR,
    input  logic                   CCC_LOCK,
    output logic                   PLL_POWERDOWN_N,
    output logic                   PLL_ARST_N,
    output logic                   FABRIC_RESET_N,
    output logic                   LOCKED_STABLE,
    output logic                   FAULT,
    output logic [2:0]             STATE,
    output logic [RETRY_CNT_W-1:0] RETRY_CNT,
    output logic [LOSS_CNT_W-1:0]  LOSS_CNT
);

    localparam int unsigned ARST_W = cnt_width(ARST_PULSE_CYCLES);
    localparam int unsigned TMO_W  = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned STAB_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned FILT_W = cnt_width(UNLOCK_FILTER_CYCLES);

    // Terminal values: ARST/filter counters count 0..N-1, timeout/stable counters 1..N.
    localparam logic [ARST_W-1:0]      ARST_LAST  = ARST_W'(ARST_PULSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]       TMO_LAST   = TMO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [STAB_W-1:0]      STAB_LAST  = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [FILT_W-1:0]      FILT_LAST  = FILT_W'(UNLOCK_FILTER_CYCLES - 1);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LAST = RETRY_CNT_W'(MAX_RETRIES);

    logic lock_s;

    ccc_lock_sync #(
        .STAGES (LOCK_SYNC_STAGES)
    ) u_lock_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d_i   (CCC_LOCK),
        .q_o   (lock_s)
    );

    state_e                 state_q,    state_d;
    logic [RETRY_CNT_W-1:0] retry_q,    retry_d;
    logic [ARST_W-1:0]      arst_cnt_q, arst_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q,  tmo_cnt_d;
    logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
    logic [FILT_W-1:0]      filt_cnt_q, filt_cnt_d;
    logic                   pwdn_n_q,   pwdn_n_d;
    logic                   arst_n_q,   arst_n_d;
    logic                   run_q,      run_d;
    logic                   fault_q,    fault_d;
    logic [TMO_W-1:0]       tmo_inc;
    logic [STAB_W-1:0]      stab_inc;
`ifdef CCC_SUP_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0]  loss_q,     loss_d;
`endif

    assign tmo_inc  = tmo_cnt_q + TMO_W'(1);
    assign stab_inc = stab_cnt_q + STAB_W'(1);

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        arst_cnt_d = arst_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        stab_cnt_d = stab_cnt_q;
        filt_cnt_d = filt_cnt_q;
`ifdef CCC_SUP_LOSS_CNT_EN
        loss_d     = loss_q;
`endif
        if (!EN) begin
            state_d = ST_IDLE;
            retry_d = '0;
        end else if (FORCE_REINIT && (state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
            state_d    = ST_ARST;
            arst_cnt_d = '0;
            retry_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ARST;
                    arst_cnt_d = '0;
                    retry_d    = '0;
                end
                ST_ARST: begin
                    // Held at zero for the whole pulse so WAIT_LOCK always starts fresh.
                    tmo_cnt_d = '0;
                    if (arst_cnt_q == ARST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        arst_cnt_d = arst_cnt_q + ARST_W'(1);
                    end
                end
                ST_WAIT_LOCK, ST_STABLE_CHK: begin
                    tmo_cnt_d = tmo_inc;
                    // Timeout outranks any lock activity seen in the same cycle.
                    if (tmo_inc == TMO_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = ST_FAULT;
                        end else begin
                            retry_d    = retry_q + RETRY_CNT_W'(1);
                            state_d    = ST_ARST;
                            arst_cnt_d = '0;
                        end
                    end else if (state_q == ST_WAIT_LOCK) begin
                        if (lock_s) begin
                            state_d    = ST_STABLE_CHK;
                            stab_cnt_d = '0;
                        end
                    end else if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        stab_cnt_d = stab_inc;
                        if (stab_inc == STAB_LAST) begin
                            state_d    = ST_RUN;
                            filt_cnt_d = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (lock_s) begin
                        filt_cnt_d = '0;
                    end else if (filt_cnt_q == FILT_LAST) begin
                        state_d    = ST_ARST;
                        arst_cnt_d = '0;
                        retry_d    = '0;
`ifdef CCC_SUP_LOSS_CNT_EN
                        if (loss_q != LOSS_CNT_W'(LOSS_CNT_MAX)) begin
                            loss_d = loss_q + LOSS_CNT_W'(1);
                        end
`endif
                    end else begin
                        filt_cnt_d = filt_cnt_q + FILT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (FAULT_CLR) begin
                        state_d    = ST_ARST;
                        arst_cnt_d = '0;
                        retry_d    = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Output flops are loaded from the next state so they change on the transition edge.
        pwdn_n_d = (state_d == ST_ARST) || (state_d == ST_WAIT_LOCK) ||
                   (state_d == ST_STABLE_CHK) || (state_d == ST_RUN);
        arst_n_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE_CHK) ||
                   (state_d == ST_RUN);
        run_d    = (state_d == ST_RUN);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            retry_q    <= '0;
            arst_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            stab_cnt_q <= '0;
            filt_cnt_q <= '0;
            pwdn_n_q   <= 1'b0;
            arst_n_q   <= 1'b0;
            run_q      <= 1'b0;
            fault_q    <= 1'b0;
`ifdef CCC_SUP_LOSS_CNT_EN
            loss_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            arst_cnt_q <= arst_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            stab_cnt_q <= stab_cnt_d;
            filt_cnt_q <= filt_cnt_d;
            pwdn_n_q   <= pwdn_n_d;
            arst_n_q   <= arst_n_d;
            run_q      <= run_d;
            fault_q    <= fault_d;
`ifdef CCC_SUP_LOSS_CNT_EN
            loss_q     <= loss_d;
`endif
        end
    end

    assign PLL_POWERDOWN_N = pwdn_n_q;
    assign PLL_ARST_N      = arst_n_q;
    assign FABRIC_RESET_N  = run_q;
    assign LOCKED_STABLE   = run_q;
    assign FAULT           = fault_q;
    assign STATE           = state_q;
    assign RETRY_CNT       = retry_q;
`ifdef CCC_SUP_LOSS_CNT_EN
    assign LOSS_CNT        = loss_q;
`else
    assign LOSS_CNT        = '0;
`endif

endmodule

// File: tb/tb_ccc_lock_supervisor.sv
// Bench for ccc_lock_supervisor: directed scenarios plus randomized stimulus,
// checked every cycle against a timestamp-based model of the sequencing rules.
module tb_ccc_lock_supervisor;

    localparam int SYNC  = 2;
    localparam int ARSTC = 4;
    localparam int TMO   = 32;
    localparam int STAB  = 8;
    localparam int FILT  = 3;
    localparam int MAXR  = 2;
`ifdef CCC_SUP_LOSS_CNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic       CLK;
    logic       RESET_N, EN, FORCE_REINIT, FAULT_CLR, CCC_LOCK;
    logic       PLL_POWERDOWN_N, PLL_ARST_N, FABRIC_RESET_N, LOCKED_STABLE, FAULT;
    logic [2:0] STATE;
    logic [1:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    ccc_lock_supervisor #(
        .LOCK_SYNC_STAGES     (SYNC),
        .ARST_PULSE_CYCLES    (ARSTC),
        .LOCK_TIMEOUT_CYCLES  (TMO),
        .LOCK_STABLE_CYCLES   (STAB),
        .UNLOCK_FILTER_CYCLES (FILT),
        .MAX_RETRIES          (MAXR)
    ) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .EN              (EN),
        .FORCE_REINIT    (FORCE_REINIT),
        .FAULT_CLR       (FAULT_CLR),
        .CCC_LOCK        (CCC_LOCK),
        .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
        .PLL_ARST_N      (PLL_ARST_N),
        .FABRIC_RESET_N  (FABRIC_RESET_N),
        .LOCKED_STABLE   (LOCKED_STABLE),
        .FAULT           (FAULT),
        .STATE           (STATE),
        .RETRY_CNT       (RETRY_CNT),
        .LOSS_CNT        (LOSS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States by their numeric codes; time spent in a phase is measured as the
    // difference between the current edge number and the edge that started it.
    int m_st, m_retry, m_loss;
    int edge_no, t_arst, t_wait, t_stab, t_hi;
    int lq[$];

    task automatic model_reset();
        m_st = 0; m_retry = 0; m_loss = 0;
        edge_no = 0; t_arst = 0; t_wait = 0; t_stab = 0; t_hi = 0;
        lq.delete();
    endtask

    task automatic model_step();
        int n, ls, nx;
        bit enter;
        edge_no++;
        n = edge_no;
        // lock seen by the decision logic is the raw value SYNC edges ago
        if (lq.size() == SYNC) ls = lq.pop_front(); else ls = 0;
        lq.push_back(CCC_LOCK ? 1 : 0);
        nx = m_st;
        enter = 1'b0;
        if (!EN) begin
            nx = 0; m_retry = 0;
        end else if (FORCE_REINIT && m_st != 0 && m_st != 5) begin
            nx = 1; m_retry = 0; enter = 1'b1;
        end else begin
            case (m_st)
                0: begin nx = 1; m_retry = 0; enter = 1'b1; end
                1: if (n - t_arst == ARSTC) begin nx = 2; enter = 1'b1; end
                2, 3: begin
                    if (n - t_wait == TMO) begin
                        if (m_retry == MAXR) nx = 5;
                        else begin m_retry++; nx = 1; enter = 1'b1; end
                    end else if (m_st == 2) begin
                        if (ls != 0) begin nx = 3; enter = 1'b1; end
                    end else if (ls == 0) begin
                        nx = 2;
                    end else if (n - t_stab == STAB) begin
                        nx = 4; enter = 1'b1;
                    end
                end
                4: begin
                    if (ls != 0) t_hi = n;
                    else if (n - t_hi == FILT) begin
                        nx = 1; m_retry = 0; enter = 1'b1;
                        if (m_loss < 255) m_loss++;
                    end
                end
                5: if (FAULT_CLR) begin nx = 1; m_retry = 0; enter = 1'b1; end
                default: nx = 0;
            endcase
        end
        if (enter) begin
            case (nx)
                1: t_arst = n;
                2: t_wait = n;
                3: t_stab = n;
                4: t_hi   = n;
                default: ;
            endcase
        end
        m_st = nx;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("cyc_state",   STATE,           m_st);
                check("cyc_pwdn_n",  PLL_POWERDOWN_N, (m_st >= 1 && m_st <= 4));
                check("cyc_arst_n",  PLL_ARST_N,      (m_st >= 2 && m_st <= 4));
                check("cyc_fab_rst", FABRIC_RESET_N,  (m_st == 4));
                check("cyc_locked",  LOCKED_STABLE,   (m_st == 4));
                check("cyc_fault",   FAULT,           (m_st == 5));
                check("cyc_retry",   RETRY_CNT,       m_retry);
                check("cyc_loss",    LOSS_CNT,        LOSS_ON ? m_loss : 0);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_state(input int s, input int budget, output int n);
        n = 0;
        while (int'(STATE) != s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("reach_state", STATE, s);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pwdn_n"}, PLL_POWERDOWN_N, 0);
        check({tag, "_arst_n"}, PLL_ARST_N, 0);
        check({tag, "_fab"},    FABRIC_RESET_N, 0);
        check({tag, "_locked"}, LOCKED_STABLE, 0);
        check({tag, "_fault"},  FAULT, 0);
        check({tag, "_state"},  STATE, 0);
        check({tag, "_retry"},  RETRY_CNT, 0);
        check({tag, "_loss"},   LOSS_CNT, 0);
    endtask

    initial begin
        int n, cnt, prev, cur, waits, t32, tr_n, n32, lk_hold, en_hold, rst_hold;
        int tr[$];
        int rq[$];
        RESET_N = 1'b0; EN = 1'b0; FORCE_REINIT = 1'b0; FAULT_CLR = 1'b0; CCC_LOCK = 1'b0;
        #3;
        check_reset_vals("rst");
        @(negedge CLK);
        RESET_N = 1'b1;
        chk_en  = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_hold", STATE, 0);

        // nominal bring-up
        EN = 1'b1;
        wait_state(1, 5, n);
        cnt = 0;
        while (STATE == 3'd1 && cnt < 20) begin
            if (PLL_ARST_N == 1'b0 && PLL_POWERDOWN_N == 1'b1) cnt++;
            @(negedge CLK);
        end
        check("arst_pulse_len", cnt, 4);
        repeat (10) @(negedge CLK);
        CCC_LOCK = 1'b1;
        wait_state(3, 10, n);
        check("lock_to_stable", n, 3);
        cnt = 0;
        while (STATE == 3'd3 && cnt < 50) begin cnt++; @(negedge CLK); end
        check("stable_len", cnt, 8);
        check("run_state", STATE, 4);
        check("run_fab", FABRIC_RESET_N, 1);
        check("run_locked", LOCKED_STABLE, 1);

        // lock loss in RUN
        repeat (3) @(negedge CLK);
        CCC_LOCK = 1'b0;
        repeat (2) @(negedge CLK);
        CCC_LOCK = 1'b1;
        repeat (6) @(negedge CLK);
        check("short_loss_state", STATE, 4);
        check("short_loss_cnt", LOSS_CNT, 0);
        CCC_LOCK = 1'b0;
        wait_state(1, 10, n);
        check("loss_latency", n, 5);
        check("loss_fab", FABRIC_RESET_N, 0);
        check("loss_cnt", LOSS_CNT, LOSS_ON);
        CCC_LOCK = 1'b1;
        wait_state(4, 40, n);

        // glitchy lock
        CCC_LOCK = 1'b0;
        FORCE_REINIT = 1'b1;
        @(negedge CLK);
        FORCE_REINIT = 1'b0;
        wait_state(2, 20, n);
        tr.delete();
        tr.push_back(int'(STATE));
        for (int i = 0; i < 60 && int'(STATE) != 4; i++) begin
            CCC_LOCK = (i == 5) ? 1'b0 : 1'b1;
            @(negedge CLK);
            tr.push_back(int'(STATE));
        end
        cnt = 0; tr_n = 0; n32 = 0;
        for (int i = 1; i < tr.size(); i++) begin
            if (tr[i-1] == 3 && tr[i] == 2) cnt++;
            if (tr[i] == 1) tr_n++;
        end
        for (int i = tr.size() - 2; i >= 0 && tr[i] == 3; i--) n32++;
        check("glitch_drop", cnt, 1);
        check("glitch_noarst", tr_n, 0);
        check("glitch_final_stable", n32, 8);
        check("glitch_retry", RETRY_CNT, 0);

        // timeout retries into FAULT
        CCC_LOCK = 1'b0;
        FORCE_REINIT = 1'b1;
        prev = int'(STATE);
        @(negedge CLK);
        FORCE_REINIT = 1'b0;
        rq.delete();
        waits = 0;
        cur = int'(STATE);
        for (int i = 0; i < 400 && cur != 5; i++) begin
            if (cur == 1 && prev != 1) rq.push_back(int'(RETRY_CNT));
            if (cur == 2) waits++;
            prev = cur;
            @(negedge CLK);
            cur = int'(STATE);
        end
        check("tmo_pulses", rq.size(), 3);
        for (int i = 0; i < 3 && i < rq.size(); i++) check("tmo_retry_seq", rq[i], i);
        check("tmo_wait_total", waits, 3 * TMO);
        check("fault_flag", FAULT, 1);
        check("fault_pwdn", PLL_POWERDOWN_N, 0);
        check("fault_arst", PLL_ARST_N, 0);
        FORCE_REINIT = 1'b1;
        @(negedge CLK);
        FORCE_REINIT = 1'b0;
        @(negedge CLK);
        check("fault_ignores_force", STATE, 5);
        FAULT_CLR = 1'b1;
        @(negedge CLK);
        FAULT_CLR = 1'b0;
        check("clr_state", STATE, 1);
        check("clr_fault", FAULT, 0);
        check("clr_retry", RETRY_CNT, 0);

        // EN low together with FORCE_REINIT in RUN
        CCC_LOCK = 1'b1;
        wait_state(4, 60, n);
        EN = 1'b0;
        FORCE_REINIT = 1'b1;
        @(negedge CLK);
        FORCE_REINIT = 1'b0;
        check("en_vs_force_state", STATE, 0);
        check("en_vs_force_pwdn", PLL_POWERDOWN_N, 0);

        // lock arriving on the timeout cycle
        CCC_LOCK = 1'b0;
        EN = 1'b1;
        wait_state(2, 10, n);
        t32 = TMO - 3;
        repeat (t32) @(negedge CLK);
        CCC_LOCK = 1'b1;
        repeat (3) @(negedge CLK);
        check("tmo_wins_state", STATE, 1);
        check("tmo_wins_retry", RETRY_CNT, 1);

        // async reset during STABLE_CHK
        wait_state(3, 20, n);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_vals("async");
        @(negedge CLK);
        RESET_N = 1'b1;

        // randomized phase
        lk_hold = 0; en_hold = 0; rst_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            FORCE_REINIT = 1'b0;
            FAULT_CLR    = 1'b0;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) RESET_N = 1'b1;
            end
            if (en_hold > 0) begin
                en_hold--;
                EN = 1'b0;
            end else begin
                EN = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) begin
                EN = 1'b0;
                en_hold = $urandom_range(0, 4);
            end
            FORCE_REINIT = ($urandom_range(0, 199) == 0);
            FAULT_CLR    = ($urandom_range(0, 29) == 0);
            if (lk_hold == 0) begin
                CCC_LOCK = ($urandom_range(0, 99) < 65);
                lk_hold  = $urandom_range(1, 45);
            end else begin
                lk_hold--;
            end
            if (rst_hold == 0 && $urandom_range(0, 999) == 0) begin
                #2;
                RESET_N  = 1'b0;
                rst_hold = 2;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
